// File: rtl/local_flit_sink.sv
// local_flit_sink
//   Terminal consumer for single-flit packets ejected from a router's local
//   port. Flits land in a 2-entry FIFO. Each popped flit is checked for a
//   destination mismatch and counted. When the optional check is compiled in,
//   each popped flit is also checked for per-source sequence continuity.
//
//   Optional feature macro: SEQ_CHECK_EN (per-source sequence table + err_seq).
//
//   Ports
//     clk, reset     clock, async active-high reset
//     id             this node's address
//     item_in/valid  incoming flit {hdr, payload{src, seq}, dest}
//     busy           FIFO full; flit not accepted this cycle
//     hold           stalls FIFO draining (slow consumer)
//     flit_counter   saturating count of checked flits
//     err_addr       sticky: misrouted flit seen
//     err_seq        sticky: sequence gap seen (0 when SEQ_CHECK_EN undefined)
//     error          err_addr | err_seq
//     led            toggles every 2^LED_SHIFT good flits
module local_flit_sink #(
   parameter int HDR_SZ    = 2,
   parameter int PL_SZ     = 8,
   parameter int ADDR_SZ   = 4,
   parameter int LED_SHIFT = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [ADDR_SZ-1:0]                id,
   input  logic [HDR_SZ+PL_SZ+ADDR_SZ-1:0]   item_in,
   input  logic                              valid,
   output logic                              busy,
   input  logic                              hold,
   output logic [19:0]                       flit_counter,
   output logic                              err_addr,
   output logic                              err_seq,
   output logic                              error,
   output logic                              led
);
   localparam int SEQ_W = PL_SZ - ADDR_SZ;

   typedef struct packed {
      logic [HDR_SZ-1:0]  hdr;
      logic [ADDR_SZ-1:0] src;
      logic [SEQ_W-1:0]   seq;
      logic [ADDR_SZ-1:0] dest;
   } flit_t;

   flit_t [1:0]          mem_q, mem_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic                 rd_ptr_q, rd_ptr_d;
   logic [1:0]           cnt_q, cnt_d;
   logic [19:0]          flit_counter_q, flit_counter_d;
   logic [LED_SHIFT-1:0] good_cnt_q, good_cnt_d;
   logic                 err_addr_q, err_addr_d;
   logic                 err_seq_q, err_seq_d;
   logic                 led_q, led_d;

   logic  push, pop, addr_bad, seq_bad, good;
   flit_t head;

   // busy comes only from the registered count: no valid->busy path.
   assign busy = (cnt_q == 2'd2);
   assign push = valid & ~busy;
   assign pop  = (cnt_q != 2'd0) & ~hold;
   assign head = mem_q[rd_ptr_q];

   assign addr_bad = pop & (head.dest != id);
   assign good     = pop & ~addr_bad & ~seq_bad;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      cnt_d    = cnt_q;
      if (push)
         mem_d[wr_ptr_q] = flit_t'(item_in);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      flit_counter_d = flit_counter_q;
      good_cnt_d     = good_cnt_q;
      led_d          = led_q;
      err_addr_d     = err_addr_q | addr_bad;
      if (pop && flit_counter_q != 20'hFFFFF)
         flit_counter_d = flit_counter_q + 20'd1;
      if (good) begin
         good_cnt_d = good_cnt_q + 1'b1;
         // toggle when the good counter wraps back to 0
         if (&good_cnt_q)
            led_d = ~led_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q          <= '0;
         wr_ptr_q       <= 1'b0;
         rd_ptr_q       <= 1'b0;
         cnt_q          <= 2'd0;
         flit_counter_q <= 20'd0;
         good_cnt_q     <= '0;
         err_addr_q     <= 1'b0;
         led_q          <= 1'b0;
      end else begin
         mem_q          <= mem_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         cnt_q          <= cnt_d;
         flit_counter_q <= flit_counter_d;
         good_cnt_q     <= good_cnt_d;
         err_addr_q     <= err_addr_d;
         led_q          <= led_d;
      end
   end

`ifdef SEQ_CHECK_EN
   logic [2**ADDR_SZ-1:0][SEQ_W-1:0] seq_tbl_q, seq_tbl_d;

   assign seq_bad = pop & (head.seq != seq_tbl_q[head.src]);

   always_comb begin
      seq_tbl_d = seq_tbl_q;
      err_seq_d = err_seq_q | seq_bad;
      // Always resync to seq+1, so a single gap reports once and recovers.
      if (pop)
         seq_tbl_d[head.src] = SEQ_W'(head.seq + 1'b1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seq_tbl_q <= '0;
         err_seq_q <= 1'b0;
      end else begin
         seq_tbl_q <= seq_tbl_d;
         err_seq_q <= err_seq_d;
      end
   end

   logic unused_bits;
   assign unused_bits = ^head.hdr;
`else
   assign seq_bad   = 1'b0;
   assign err_seq_d = 1'b0;
   assign err_seq_q = err_seq_d;

   logic unused_bits;
   assign unused_bits = ^{head.hdr, head.src, head.seq};
`endif

   assign flit_counter = flit_counter_q;
   assign err_addr     = err_addr_q;
   assign err_seq      = err_seq_q;
   assign error        = err_addr_q | err_seq_q;
   assign led          = led_q;

endmodule

// File: tb/tb_local_flit_sink.sv
// Directed bench for local_flit_sink (LED_SHIFT=2 so LED toggles are cheap
// to reach). Main traffic is a per-cycle vector table; reset, saturation and
// sequence-table cases are hand-written sequences.
module tb_local_flit_sink;
   localparam int HDR_SZ = 2, PL_SZ = 8, ADDR_SZ = 4, LED_SHIFT = 2;
   localparam int FW = HDR_SZ + PL_SZ + ADDR_SZ;

`ifdef SEQ_CHECK_EN
   localparam bit SEQ_ON = 1'b1;
`else
   localparam bit SEQ_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, valid, hold;
   logic [3:0]    id;
   logic [FW-1:0] item_in;
   logic          busy, err_addr, err_seq, error, led;
   logic [19:0]   flit_counter;
   int            checks = 0, errors = 0;

   always #5 clk = ~clk;

   local_flit_sink #(.HDR_SZ(HDR_SZ), .PL_SZ(PL_SZ), .ADDR_SZ(ADDR_SZ),
                     .LED_SHIFT(LED_SHIFT)) dut (
      .clk(clk), .reset(reset), .id(id), .item_in(item_in), .valid(valid),
      .busy(busy), .hold(hold), .flit_counter(flit_counter),
      .err_addr(err_addr), .err_seq(err_seq), .error(error), .led(led));

   typedef struct {
      logic          vld;
      logic          hld;
      logic [FW-1:0] item;
      logic          e_busy;
      logic [19:0]   e_cnt;
      logic          e_eaddr;
      logic          e_led;
   } vec_t;

   vec_t tbl[21];

   // hdr deliberately nonzero: it must be ignored
   function automatic logic [FW-1:0] mk(input logic [3:0] dest, input logic [3:0] src,
                                        input logic [3:0] seq);
      return {2'b10, src, seq, dest};
   endfunction

   function automatic vec_t row(input logic vld, input logic hld, input logic [FW-1:0] item,
                                input logic e_busy, input int e_cnt, input logic e_eaddr,
                                input logic e_led);
      vec_t v;
      v.vld = vld; v.hld = hld; v.item = item; v.e_busy = e_busy;
      v.e_cnt = 20'(e_cnt); v.e_eaddr = e_eaddr; v.e_led = e_led;
      return v;
   endfunction

   task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_busy, input logic [19:0] e_cnt,
                          input logic e_ea, input logic e_es, input logic e_led);
      chk({tag, " busy"},     20'(busy),     20'(e_busy));
      chk({tag, " cnt"},      flit_counter,  e_cnt);
      chk({tag, " err_addr"}, 20'(err_addr), 20'(e_ea));
      chk({tag, " err_seq"},  20'(err_seq),  20'(e_es));
      chk({tag, " error"},    20'(error),    20'(e_ea | e_es));
      chk({tag, " led"},      20'(led),      20'(e_led));
   endtask

   // entered and left on a negedge; reset spans one rising edge
   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // accept at edge N, checked at N+1; returns just after N+1
   task automatic send_one(input logic [FW-1:0] f);
      valid = 1'b1; item_in = f;
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; valid = 1'b0; hold = 1'b0; id = 4'd3; item_in = '0;

      // back-to-back traffic, led toggles after good flits 4 and 8
      for (int i = 0; i < 10; i++)
         tbl[i] = row(1'b1, 1'b0, mk(3, 5, 4'(i)), 1'b0, i, 1'b0, (i >= 4 && i < 8));
      tbl[10] = row(1'b0, 1'b0, '0, 1'b0, 10, 1'b0, 1'b0);
      // hold with valid high: 2 accepts, then full
      tbl[11] = row(1'b1, 1'b1, mk(3, 5, 10), 1'b0, 10, 1'b0, 1'b0);
      tbl[12] = row(1'b1, 1'b1, mk(7, 5, 11), 1'b1, 10, 1'b0, 1'b0);
      tbl[13] = row(1'b1, 1'b1, mk(3, 5, 12), 1'b1, 10, 1'b0, 1'b0);
      tbl[14] = row(1'b1, 1'b1, mk(3, 5, 12), 1'b1, 10, 1'b0, 1'b0);
      tbl[15] = row(1'b1, 1'b1, mk(3, 5, 12), 1'b1, 10, 1'b0, 1'b0);
      // release: good flit first, then the misrouted one (proves order)
      tbl[16] = row(1'b0, 1'b0, '0, 1'b0, 11, 1'b0, 1'b0);
      tbl[17] = row(1'b0, 1'b0, '0, 1'b0, 12, 1'b1, 1'b0);
      tbl[18] = row(1'b1, 1'b0, mk(3, 5, 12), 1'b0, 12, 1'b1, 1'b0);
      tbl[19] = row(1'b0, 1'b0, '0, 1'b0, 13, 1'b1, 1'b1);
      tbl[20] = row(1'b0, 1'b0, '0, 1'b0, 13, 1'b1, 1'b1);

      @(negedge clk);
      chk_all("reset", 1'b0, 20'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < 21; i++) begin
         valid = tbl[i].vld; hold = tbl[i].hld; item_in = tbl[i].item;
         @(negedge clk);
         chk_all($sformatf("vec%0d", i), tbl[i].e_busy, tbl[i].e_cnt,
                 tbl[i].e_eaddr, 1'b0, tbl[i].e_led);
      end
      valid = 1'b0; hold = 1'b0;

      // sequence wrap 15 -> 0 from src 2 is legal
      pulse_reset();
      for (int s = 0; s < 16; s++)
         send_one(mk(3, 2, 4'(s)));
      send_one(mk(3, 2, 0));
      chk("wrap err_seq", 20'(err_seq), 20'd0);
      chk("wrap cnt", flit_counter, 20'd17);

      // gap 1 -> 3 from src 5
      send_one(mk(3, 5, 0));
      send_one(mk(3, 5, 1));
      chk("seq01 err_seq", 20'(err_seq), 20'd0);
      send_one(mk(3, 5, 3));
      chk("gap err_seq", 20'(err_seq), 20'(SEQ_ON));
      chk("gap error", 20'(error), 20'(SEQ_ON));
      send_one(mk(3, 5, 4));
      chk("after gap err_seq", 20'(err_seq), 20'(SEQ_ON));
      chk("after gap cnt", flit_counter, 20'd21);
      chk("after gap err_addr", 20'(err_addr), 20'd0);

      // saturation and reset with a full FIFO
      pulse_reset();
      hold = 1'b1; valid = 1'b1; item_in = mk(3, 5, 0);
      @(negedge clk);
      item_in = mk(3, 5, 1);
      @(negedge clk);
      chk("fill busy", 20'(busy), 20'd1);
      force dut.flit_counter_q = 20'hFFFFF;
      #1 release dut.flit_counter_q;
      item_in = mk(3, 5, 2); hold = 1'b0;
      @(negedge clk);
      chk("sat cnt", flit_counter, 20'hFFFFF);
      chk("sat busy", 20'(busy), 20'd0);
      hold = 1'b1;
      @(negedge clk);
      chk("refill busy", 20'(busy), 20'd1);
      valid = 1'b0; item_in = mk(7, 1, 9);
      @(negedge clk);
      force dut.err_addr_q = 1'b1;
      force dut.led_q = 1'b1;
      #1 release dut.err_addr_q;
      release dut.led_q;
      reset = 1'b1;
      #1 chk_all("async reset", 1'b0, 20'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0; hold = 1'b0;
      @(negedge clk);
      chk("post reset discard cnt", flit_counter, 20'd0);
      send_one(mk(3, 5, 0));
      chk_all("post reset flit", 1'b0, 20'd1, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
